// File: rtl/ddr_port0_pixel_writer.sv
// DDR port-0 pixel writer: moves computed pixels into the MCB write data FIFO
// and issues write bursts so every frame lands contiguously from BASE_ADDR.
module ddr_port0_pixel_writer #(
  parameter logic [29:0] BASE_ADDR = 30'd0,
  parameter int          MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  resolution,
  input  logic        update,
  input  logic [31:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        mem_calib_done,
  input  logic        wr_full,
  input  logic        wr_empty,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, FILL, CMD, DRAIN} state_t;

  localparam logic [6:0]  MAX_LEN  = 7'(MAX_BURST);
  localparam logic [20:0] MAX_LEN_W = 21'(MAX_BURST);

  function automatic logic [20:0] res_pixels(input logic [3:0] res);
    case (res)
      4'b0000: res_pixels = 21'd307200;
      4'b0001: res_pixels = 21'd480000;
      4'b0011: res_pixels = 21'd786432;
      4'b0010: res_pixels = 21'd921600;
      default: res_pixels = 21'd1310720;
    endcase
  endfunction

  state_t      state;
  state_t      state_next;
  logic [1:0]  calib_sync;
  logic [20:0] total_pixels;
  logic        upd_pending;
  logic [20:0] pixel_index;
  logic [6:0]  word_cnt;
  logic [6:0]  burst_len;

  logic        drain_done;
  logic        wrap;
  logic [20:0] index_sum;
  logic [20:0] index_next;
  logic [20:0] total_next;
  logic [20:0] start_index;
  logic [20:0] remaining;
  logic [6:0]  len_next;

  // Index, frame size and burst size as they will be on entry to the next FILL.
  always_comb begin
    drain_done  = (state == DRAIN) && wr_empty;
    index_sum   = pixel_index + 21'(burst_len);
    wrap        = drain_done && (index_sum == total_pixels);
    index_next  = wrap ? 21'd0 : index_sum;
    total_next  = (wrap && upd_pending) ? res_pixels(resolution) : total_pixels;
    start_index = (state == DRAIN) ? index_next : pixel_index;
    remaining   = total_next - start_index;
    len_next    = (remaining >= MAX_LEN_W) ? MAX_LEN : remaining[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    pixel_ready = 1'b0;
    cmd_en      = 1'b0;
    case (state)
      IDLE: if (calib_sync[1]) state_next = FILL;
      FILL: begin
        pixel_ready = (word_cnt < burst_len) && !wr_full;
        if (pixel_valid && pixel_ready && (word_cnt + 7'd1 == burst_len))
          state_next = CMD;
      end
      CMD: if (!cmd_full) begin
        cmd_en     = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: if (wr_empty) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  assign wr_en         = pixel_valid && pixel_ready;
  assign wr_data       = pixel_data;
  assign wr_mask       = 4'b0000;
  assign cmd_instr     = 3'b000;
  assign cmd_bl        = 6'(burst_len - 7'd1);
  assign cmd_byte_addr = BASE_ADDR + {7'd0, pixel_index, 2'b00};

  // An update seen in the wrap cycle stays pending for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      calib_sync   <= 2'b00;
      total_pixels <= res_pixels(resolution);
      upd_pending  <= 1'b0;
      pixel_index  <= 21'd0;
      word_cnt     <= 7'd0;
      burst_len    <= 7'd1;
      frame_done   <= 1'b0;
      frame_count  <= 8'd0;
    end else begin
      calib_sync <= {calib_sync[0], mem_calib_done};
      frame_done <= wrap;
      if (wrap) begin
        frame_count  <= frame_count + 8'd1;
        total_pixels <= total_next;
        upd_pending  <= update;
      end else if (update) begin
        upd_pending <= 1'b1;
      end
      if (wr_en) word_cnt <= word_cnt + 7'd1;
      if (drain_done) begin
        pixel_index <= index_next;
        word_cnt    <= 7'd0;
      end
      if ((state_next == FILL) && (state != FILL)) burst_len <= len_next;
    end
  end

endmodule

// File: tb/tb_ddr_port0_pixel_writer.sv
// Self-checking bench for ddr_port0_pixel_writer: a table-driven end-of-frame run
// with MAX_BURST=7 plus hand sequences on a MAX_BURST=64 instance.
module tb_ddr_port0_pixel_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: MAX_BURST=64
  logic        reset_a, update_a, pvalid_a, calib_a, wr_full_a, wr_empty_a, cmd_full_a;
  logic [3:0]  res_a;
  logic [31:0] pdata_a;
  logic        ready_a, wr_en_a, cmd_en_a, fd_a;
  logic [31:0] wr_data_a;
  logic [3:0]  mask_a;
  logic [2:0]  instr_a;
  logic [5:0]  bl_a;
  logic [29:0] addr_a;
  logic [7:0]  fc_a;

  // Instance B: MAX_BURST=7
  logic        reset_b, update_b, pvalid_b, calib_b, wr_full_b, wr_empty_b, cmd_full_b;
  logic [3:0]  res_b;
  logic [31:0] pdata_b;
  logic        ready_b, wr_en_b, cmd_en_b, fd_b;
  logic [31:0] wr_data_b;
  logic [3:0]  mask_b;
  logic [2:0]  instr_b;
  logic [5:0]  bl_b;
  logic [29:0] addr_b;
  logic [7:0]  fc_b;

  ddr_port0_pixel_writer #(.BASE_ADDR(30'd0), .MAX_BURST(64)) dut_a (
    .clk(clk), .reset(reset_a), .resolution(res_a), .update(update_a),
    .pixel_data(pdata_a), .pixel_valid(pvalid_a), .pixel_ready(ready_a),
    .mem_calib_done(calib_a), .wr_full(wr_full_a), .wr_empty(wr_empty_a),
    .cmd_full(cmd_full_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .wr_mask(mask_a),
    .cmd_en(cmd_en_a), .cmd_instr(instr_a), .cmd_bl(bl_a), .cmd_byte_addr(addr_a),
    .frame_done(fd_a), .frame_count(fc_a)
  );

  ddr_port0_pixel_writer #(.BASE_ADDR(30'd0), .MAX_BURST(7)) dut_b (
    .clk(clk), .reset(reset_b), .resolution(res_b), .update(update_b),
    .pixel_data(pdata_b), .pixel_valid(pvalid_b), .pixel_ready(ready_b),
    .mem_calib_done(calib_b), .wr_full(wr_full_b), .wr_empty(wr_empty_b),
    .cmd_full(cmd_full_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .wr_mask(mask_b),
    .cmd_en(cmd_en_b), .cmd_instr(instr_b), .cmd_bl(bl_b), .cmd_byte_addr(addr_b),
    .frame_done(fd_b), .frame_count(fc_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic        calib, valid, wfull, cfull, wempty;
    logic        ready, wen, cen, fd;
    logic [5:0]  bl;
    logic [29:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic v, input logic wf, input logic cf,
                              input logic we, input logic r, input logic w, input logic ce,
                              input logic fd, input logic [5:0] bl, input logic [29:0] addr);
    vec_t t;
    t.calib = c; t.valid = v; t.wfull = wf; t.cfull = cf; t.wempty = we;
    t.ready = r; t.wen = w; t.cen = ce; t.fd = fd; t.bl = bl; t.addr = addr;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t v, input int i);
    @(negedge clk);
    calib_b    = v.calib;
    pvalid_b   = v.valid;
    wr_full_b  = v.wfull;
    cmd_full_b = v.cfull;
    wr_empty_b = v.wempty;
    pdata_b    = 32'hB000_0000 + 32'(i);
    #1;
  endtask

  // Instance A driver: pixel_data advances only after a word was accepted.
  logic        acc_a = 1'b0;
  logic [31:0] data_a = 32'h0000_1000;
  int          word_total_a = 0;

  task automatic cycleA(input logic v, input logic wf, input logic cf, input logic we);
    @(negedge clk);
    if (acc_a) data_a++;
    pvalid_a   = v;
    wr_full_a  = wf;
    cmd_full_a = cf;
    wr_empty_a = we;
    pdata_a    = data_a;
    #1;
    acc_a = v && ready_a;
    if (acc_a) word_total_a++;
  endtask

  // Instance A scoreboard: word order, burst sizes and addresses from a pointer model.
  logic        mon_a = 1'b0;
  logic [31:0] exp_word = 32'd0;
  int          burst_words = 0;
  int          cmd_cnt = 0;
  int          done_cnt = 0;
  int          model_idx = 0;
  int          model_total = 307200;
  int          model_next_total = 307200;
  logic        prev_fd = 1'b0;

  always @(negedge clk) begin
    int exp_len;
    #2;
    if (mon_a) begin
      if (wr_full_a) checkOutput("a_ready_while_wr_full", 32'(ready_a), 32'd0);
      if (cmd_full_a) checkOutput("a_cmd_en_while_cmd_full", 32'(cmd_en_a), 32'd0);
      if (wr_en_a) begin
        checkOutput("a_word_order", wr_data_a, exp_word);
        exp_word++;
        burst_words++;
      end
      if (cmd_en_a) begin
        exp_len = (model_total - model_idx >= 64) ? 64 : model_total - model_idx;
        checkOutput("a_cmd_bl", 32'(bl_a), 32'(exp_len - 1));
        checkOutput("a_cmd_addr", 32'(addr_a), 32'(model_idx * 4));
        checkOutput("a_burst_words", 32'(burst_words), 32'(exp_len));
        checkOutput("a_cmd_instr", 32'(instr_a), 32'd0);
        burst_words = 0;
        cmd_cnt++;
        model_idx += exp_len;
        if (model_idx == model_total) begin
          model_idx   = 0;
          model_total = model_next_total;
        end
      end
      if (fd_a) begin
        checkOutput("a_frame_done_width", 32'(prev_fd), 32'd0);
        done_cnt++;
      end
      prev_fd = fd_a;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;
    int   w0;

    reset_a = 1'b1; update_a = 1'b0; pvalid_a = 1'b0; calib_a = 1'b0; res_a = 4'b0000;
    wr_full_a = 1'b0; wr_empty_a = 1'b1; cmd_full_a = 1'b0; pdata_a = 32'd0;
    reset_b = 1'b1; update_b = 1'b0; pvalid_b = 1'b0; calib_b = 1'b0; res_b = 4'b0000;
    wr_full_b = 1'b0; wr_empty_b = 1'b0; cmd_full_b = 1'b0; pdata_b = 32'd0;

    // ---- Instance B: last two bursts of a VGA frame, MAX_BURST=7 ----
    repeat (3) @(negedge clk);
    reset_b = 1'b0;
    // A whole frame is far too long to simulate, so start near its end.
    force dut_b.pixel_index = 21'd307188;
    @(negedge clk);
    release dut_b.pixel_index;

    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,1,0,0,0, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,0,0, 1,1,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,0, 6'd0, 30'd0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1,1,0,0,0, 1,1,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,1,0, 6'd6, 30'd1228752));
    vecs.push_back(mk(1,1,0,0,0, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,0,1, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,0,0, 1,1,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,0, 6'd0, 30'd0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,1,0,0,0, 1,1,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,1,0,0,0, 0,0,1,0, 6'd4, 30'd1228780));
    vecs.push_back(mk(1,0,0,0,1, 0,0,0,0, 6'd0, 30'd0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,1, 6'd0, 30'd0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,0, 6'd0, 30'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput($sformatf("b_row%0d_ready", i), 32'(ready_b), 32'(vecs[i].ready));
      checkOutput($sformatf("b_row%0d_wr_en", i), 32'(wr_en_b), 32'(vecs[i].wen));
      checkOutput($sformatf("b_row%0d_cmd_en", i), 32'(cmd_en_b), 32'(vecs[i].cen));
      checkOutput($sformatf("b_row%0d_frame_done", i), 32'(fd_b), 32'(vecs[i].fd));
      if (vecs[i].wen) checkOutput($sformatf("b_row%0d_wr_data", i), wr_data_b, pdata_b);
      if (vecs[i].cen) begin
        checkOutput($sformatf("b_row%0d_cmd_bl", i), 32'(bl_b), 32'(vecs[i].bl));
        checkOutput($sformatf("b_row%0d_cmd_addr", i), 32'(addr_b), 32'(vecs[i].addr));
      end
    end
    checkOutput("b_frame_count", 32'(fc_b), 32'd1);
    checkOutput("b_addr_after_wrap", 32'(addr_b), 32'd0);

    // ---- Instance A: reset values ----
    repeat (3) cycleA(1, 0, 0, 1);
    checkOutput("a_rst_ready", 32'(ready_a), 32'd0);
    checkOutput("a_rst_wr_en", 32'(wr_en_a), 32'd0);
    checkOutput("a_rst_cmd_en", 32'(cmd_en_a), 32'd0);
    checkOutput("a_rst_frame_done", 32'(fd_a), 32'd0);
    checkOutput("a_rst_cmd_bl", 32'(bl_a), 32'd0);
    checkOutput("a_rst_cmd_addr", 32'(addr_a), 32'd0);
    checkOutput("a_rst_cmd_instr", 32'(instr_a), 32'd0);
    checkOutput("a_rst_wr_mask", 32'(mask_a), 32'd0);
    checkOutput("a_rst_frame_count", 32'(fc_a), 32'd0);
    reset_a = 1'b0;

    // Two bursts before the VGA wrap.
    force dut_a.pixel_index = 21'd307072;
    cycleA(0, 0, 0, 1);
    release dut_a.pixel_index;
    model_idx = 307072; model_total = 307200; model_next_total = 307200;
    exp_word = data_a; burst_words = 0; mon_a = 1'b1;

    // ---- Calibration gating and latency ----
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cycleA(1, 0, 0, 1);
      if (ready_a) seen = 1'b1;
    end
    checkOutput("a_calib_gate", 32'(seen), 32'd0);
    calib_a = 1'b1;
    cycleA(1, 0, 1, 1);
    checkOutput("a_calib_lat1", 32'(ready_a), 32'd0);
    cycleA(1, 0, 1, 1);
    checkOutput("a_calib_lat2", 32'(ready_a), 32'd0);
    cycleA(1, 0, 1, 1);
    checkOutput("a_calib_lat3", 32'(ready_a), 32'd1);

    // ---- Backpressure: wr_full toggling, cmd_full held ----
    w0 = word_total_a - 1;
    for (int k = 0; k < 400 && (word_total_a - w0) < 64; k++)
      cycleA(1, ((k / 3) % 2) == 1, 1, 1);
    checkOutput("a_burst1_filled", 32'(word_total_a - w0), 32'd64);
    repeat (20) cycleA(1, 0, 1, 1);
    checkOutput("a_cmd_held", 32'(cmd_cnt), 32'd0);
    cycleA(1, 0, 0, 0);
    checkOutput("a_cmd_after_release", 32'(cmd_en_a), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cycleA(1, 0, 0, 0);
      checkOutput("a_drain_ready", 32'(ready_a), 32'd0);
    end
    checkOutput("a_one_cmd", 32'(cmd_cnt), 32'd1);

    // ---- Update during the frame: VGA frame ends unchanged, next frame is SVGA ----
    res_a = 4'b0001;
    update_a = 1'b1;
    model_next_total = 480000;
    cycleA(1, 0, 0, 1);
    update_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      cycleA(1, 0, 0, 1);
      if (fd_a) seen = 1'b1;
    end
    checkOutput("a_frame1_done", 32'(seen), 32'd1);
    checkOutput("a_frame1_count", 32'(fc_a), 32'd1);
    checkOutput("a_frame1_next_addr", 32'(addr_a), 32'd0);
    checkOutput("a_frame1_cmds", 32'(cmd_cnt), 32'd2);

    // Jump near the end of the SVGA frame during its first burst.
    force dut_a.pixel_index = 21'd479872;
    model_idx = 479872;
    cycleA(1, 0, 0, 1);
    release dut_a.pixel_index;
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      cycleA(1, (k % 7) == 3, 0, 1);
      if (fd_a) seen = 1'b1;
    end
    checkOutput("a_frame2_done", 32'(seen), 32'd1);
    checkOutput("a_frame2_count", 32'(fc_a), 32'd2);
    checkOutput("a_frame2_cmds", 32'(cmd_cnt), 32'd4);

    // ---- Reset after 30 words of a burst ----
    w0 = word_total_a;
    for (int k = 0; k < 200 && (word_total_a - w0) < 30; k++) cycleA(1, 0, 0, 1);
    mon_a = 1'b0;
    reset_a = 1'b1;
    cycleA(0, 0, 0, 1);
    checkOutput("a_mid_rst_ready", 32'(ready_a), 32'd0);
    checkOutput("a_mid_rst_wr_en", 32'(wr_en_a), 32'd0);
    checkOutput("a_mid_rst_cmd_en", 32'(cmd_en_a), 32'd0);
    checkOutput("a_mid_rst_frame_done", 32'(fd_a), 32'd0);
    checkOutput("a_mid_rst_cmd_bl", 32'(bl_a), 32'd0);
    checkOutput("a_mid_rst_cmd_addr", 32'(addr_a), 32'd0);
    checkOutput("a_mid_rst_frame_count", 32'(fc_a), 32'd0);
    reset_a = 1'b0;
    exp_word = data_a; burst_words = 0; cmd_cnt = 0;
    model_idx = 0; model_total = 480000; model_next_total = 480000;
    prev_fd = 1'b0; mon_a = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cycleA(1, 0, 0, 1);
      if (cmd_en_a) begin
        seen = 1'b1;
        checkOutput("a_post_rst_cmd_addr", 32'(addr_a), 32'd0);
        checkOutput("a_post_rst_cmd_bl", 32'(bl_a), 32'd63);
      end
    end
    checkOutput("a_post_rst_cmd_seen", 32'(seen), 32'd1);
    cycleA(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ddr_port0_pixel_writer.md
# ddr_port0_pixel_writer

Upstream neighbour of the DDR port-1 read controller. It accepts computed Mandelbrot pixels over a valid/ready stream and pushes them into the MCB port-0 write data FIFO. It issues write commands in bursts of up to MAX_BURST words, so each frame lands in DDR as one contiguous 32-bit-per-pixel image starting at BASE_ADDR. The port-1 reader then streams that image to HDMI.

## Interface
- BASE_ADDR, 30'd0, byte address of pixel 0 in DDR.
- MAX_BURST, 64, maximum words per write command; legal range 1..64.
- clk  in  1  MCB user-port clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- resolution  in  4  0000 VGA 307200 px, 0001 SVGA 480000, 0011 XGA 786432, 0010 720p 921600, any other value SXGA 1310720.
- update  in  1  request to re-latch `resolution`.
- pixel_data  in  32  pixel word from the compute engine.
- pixel_valid  in  1  `pixel_data` is valid.
- pixel_ready  out  1  block accepts the word this cycle.
- mem_calib_done  in  1  MCB calibration complete; asynchronous to this block's logic.
- wr_full  in  1  MCB write FIFO is full.
- wr_empty  in  1  MCB write FIFO is empty.
- cmd_full  in  1  MCB command FIFO is full.
- wr_en  out  1  write strobe to the MCB data FIFO.
- wr_data  out  32  write data to the MCB data FIFO.
- wr_mask  out  4  byte mask; constant 0.
- cmd_en  out  1  one-cycle command strobe.
- cmd_instr  out  3  command; constant 3'b000 (write).
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  30  byte address of the burst.
- frame_done  out  1  one-cycle pulse after the last burst of a frame is drained.
- frame_count  out  8  number of completed frames; wraps modulo 256.

## Operation
- **Calibration sync:** `mem_calib_done` passes through a 2-flop synchronizer, calib_sync[1:0].
- **Pixel count latch:** total_pixels is 21 bits.
  - Loaded from `resolution` on reset.
  - An `update` pulse sets upd_pending.
  - total_pixels is re-latched, and upd_pending cleared, only at a frame boundary: in the cycle the pointer wraps to 0.
- **Pointer:** pixel_index is 21 bits, counted in words.
  - cmd_byte_addr = BASE_ADDR + (pixel_index << 2), truncated to 30 bits.
- **Burst sizing:** burst_len = min(MAX_BURST, total_pixels - pixel_index).
  - burst_len is computed when entering FILL and held for the whole burst.
- **FSM states:**
  - IDLE: wait for calib_sync[1]=1, then go to FILL.
  - FILL:
    - pixel_ready = (word_cnt < burst_len) && !wr_full.
    - wr_en = pixel_valid && pixel_ready; wr_data = pixel_data (combinational pass-through).
    - word_cnt increments on each accepted word.
    - When word_cnt reaches burst_len, go to CMD.
  - CMD:
    - When !cmd_full: cmd_en=1 for exactly one cycle, cmd_bl = burst_len-1, address from the current pixel_index; then go to DRAIN.
    - While cmd_full=1, stay in CMD with cmd_en=0.
  - DRAIN:
    - Wait for wr_empty=1.
    - Then pixel_index += burst_len. If the result equals total_pixels: pixel_index ← 0, pulse frame_done, increment frame_count, apply any pending update.
    - Clear word_cnt and go to FILL.
- pixel_ready is 0 in IDLE, CMD and DRAIN.
- **Simultaneous events:**
  - An `update` arriving in the wrap cycle is captured as pending and applied at the next wrap.
  - `reset` overrides everything.

## Timing
- **Reset values:**
  - FSM in IDLE.
  - cmd_en, pixel_ready, wr_en, frame_done = 0.
  - cmd_bl = 0, cmd_byte_addr = BASE_ADDR, cmd_instr = 0, wr_mask = 0.
  - pixel_index, word_cnt, frame_count = 0; upd_pending = 0.
- **Reset mid-burst:** words already pushed to the MCB FIFO are abandoned; no command is issued for them.
- **Calibration latency:** after `mem_calib_done` rises, pixel_ready can first assert 3 cycles later (2 synchronizer flops plus the IDLE→FILL transition).
- **Handshake:** a word transfers on any edge with pixel_valid && pixel_ready. Throughput is 1 word per cycle inside FILL.
- **Burst cadence:** CMD is reached the cycle after the last accepted word. With cmd_full=0, cmd_en asserts in that cycle. DRAIN lasts at least 1 cycle. FILL re-opens the cycle after wr_empty is seen.
- **wr_full in FILL:** forces pixel_ready=0 in the same cycle (combinational). No word is lost or duplicated.
- **frame_done:** asserts in the cycle immediately after the final DRAIN cycle of a frame; width is exactly 1 cycle.

## Test plan
1. **Calibration gating:** hold mem_calib_done=0 for 100 cycles with pixel_valid=1 -> pixel_ready stays 0. Raise it -> pixel_ready=1 exactly 3 cycles later.
2. **VGA frame, MAX_BURST=64, pixel_valid held high:** -> 4800 cmd_en pulses, each with cmd_bl=63. Addresses run 0, 256, …, 1228544. One frame_done pulse; frame_count=1; the next address is 0.
3. **Partial burst, MAX_BURST=7, VGA:** -> 43885 bursts with cmd_bl=6, then one burst with cmd_bl=4 at byte address 1228780. frame_done follows that burst.
4. **Backpressure:** toggle wr_full every 3 cycles and hold cmd_full=1 for 20 cycles in CMD -> cmd_en stays low while cmd_full=1 and pulses once after it drops. The scoreboard sees exactly 64 words per burst, in order, with no duplicates.
5. **Mid-frame update:** switch VGA→SVGA and pulse update halfway through the frame -> the current frame still ends at 307200 pixels. The next frame ends at 480000 pixels (7500 bursts).
6. **Reset mid-burst:** assert reset after 30 words of a burst -> all outputs return to their reset values the next cycle. After calibration, the first command has address BASE_ADDR and cmd_bl=63.
